// File: rtl/arduino_link_ctrl.sv
// arduino_link_ctrl
//   Shares the single-wire data line to the Arduino between two payload
//   sources. A granted payload is sent as a framed word (start bit, DATA_W
//   data bits LSB first, stop bit). The block then waits for the Arduino's
//   acknowledge edge or for a timeout.
//
// Ports
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   req_a    requester A (switch logic) has a payload, level
//   data_a   payload A, sampled in the grant cycle
//   req_b    requester B (CPU port) has a payload, level
//   data_b   payload B, sampled in the grant cycle
//   ack_in   Arduino acknowledge, asynchronous to clk
//   gnt_a    one-cycle pulse: payload A accepted
//   gnt_b    one-cycle pulse: payload B accepted
//   busy     high while a frame or an acknowledge wait is in progress
//   data     serial line to the Arduino, idles high
//   done     one-cycle pulse: frame acknowledged
//   err      one-cycle pulse: acknowledge timeout
module arduino_link_ctrl #(
    parameter int CLKS_PER_BIT     = 10416,
    parameter int DATA_W           = 8,
    parameter int ACK_TIMEOUT_BITS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              ack_in,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              busy,
    output logic              data,
    output logic              done,
    output logic              err
);

    localparam int TMR_W  = $clog2(CLKS_PER_BIT);
    localparam int TO_CYC = ACK_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BITS,
        STOP,
        WAIT_ACK
    } state_t;

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [TO_W-1:0]   to_cnt, to_nxt;
    logic              last_b, last_b_nxt;
    logic              data_q, data_nxt;
    logic              ack_s1, ack_s2, ack_d;
    logic              ack_rise;
    logic              bit_end;
    logic              pick_a, pick_b;

    // Two-flop synchronizer for the asynchronous acknowledge, plus an edge register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
            ack_d  <= 1'b0;
        end else begin
            ack_s1 <= ack_in;
            ack_s2 <= ack_s1;
            ack_d  <= ack_s2;
        end
    end

    assign ack_rise = ack_s2 & ~ack_d;
    assign bit_end  = (timer == TMR_W'(CLKS_PER_BIT - 1));

    // Round-robin arbitration: on a tie, the requester not granted last time wins.
    // Grants are gated by reset_n so that no pulse appears while reset is held.
    assign pick_a = reset_n & req_a & (~req_b | last_b);
    assign pick_b = reset_n & req_b & (~req_a | ~last_b);

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        idx_nxt    = idx;
        shift_nxt  = shift;
        to_nxt     = to_cnt;
        last_b_nxt = last_b;
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (pick_a) begin
                    gnt_a      = 1'b1;
                    shift_nxt  = data_a;
                    last_b_nxt = 1'b0;
                    state_nxt  = START;
                end else if (pick_b) begin
                    gnt_b      = 1'b1;
                    shift_nxt  = data_b;
                    last_b_nxt = 1'b1;
                    state_nxt  = START;
                end
            end
            START: begin
                timer_nxt = bit_end ? '0 : timer + TMR_W'(1);
                if (bit_end) begin
                    idx_nxt   = '0;
                    state_nxt = BITS;
                end
            end
            BITS: begin
                timer_nxt = bit_end ? '0 : timer + TMR_W'(1);
                if (bit_end) begin
                    if (idx == IDX_W'(DATA_W - 1)) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                timer_nxt = bit_end ? '0 : timer + TMR_W'(1);
                if (bit_end) begin
                    to_nxt    = '0;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // An acknowledge arriving in the expiry cycle still counts as done.
                if (ack_rise) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (to_cnt == TO_W'(TO_CYC - 1)) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    to_nxt = to_cnt + TO_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The line level is registered from the next state so the wire is glitch-free.
    always_comb begin
        data_nxt = 1'b1;
        case (state_nxt)
            START:   data_nxt = 1'b0;
            BITS:    data_nxt = shift_nxt[idx_nxt];
            default: data_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            timer  <= '0;
            idx    <= '0;
            shift  <= '0;
            to_cnt <= '0;
            last_b <= 1'b1;
            data_q <= 1'b1;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            idx    <= idx_nxt;
            shift  <= shift_nxt;
            to_cnt <= to_nxt;
            last_b <= last_b_nxt;
            data_q <= data_nxt;
        end
    end

    assign busy = (state != IDLE);
    assign data = data_q;

endmodule

// File: tb/tb_arduino_link_ctrl.sv
// Scoreboard bench for arduino_link_ctrl: the stimulus pushes expected frames,
// and a monitor pops one entry on each grant and checks the serial frame and its ending.
module tb_arduino_link_ctrl;

    localparam int CPB    = 4;
    localparam int DW     = 8;
    localparam int TOB    = 16;
    localparam int TO_CYC = TOB * CPB;

    localparam int R_DONE = 0;
    localparam int R_ERR  = 1;
    localparam int R_RST  = 2;
    localparam int R_NONE = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_a = 1'b0;
    logic          req_b = 1'b0;
    logic          ack_in = 1'b0;
    logic [DW-1:0] data_a = '0;
    logic [DW-1:0] data_b = '0;
    logic          gnt_a, gnt_b, busy, data, done, err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit            src;   // 0 = A, 1 = B
        logic [DW-1:0] pay;
        int            res;
        bit            imm;   // grant must land in the first IDLE cycle
    } exp_t;

    exp_t q[$];

    arduino_link_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_W(DW),
        .ACK_TIMEOUT_BITS(TOB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_a(req_a),
        .data_a(data_a),
        .req_b(req_b),
        .data_b(data_b),
        .ack_in(ack_in),
        .gnt_a(gnt_a),
        .gnt_b(gnt_b),
        .busy(busy),
        .data(data),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input bit src, input logic [DW-1:0] pay, input int res, input bit imm);
        exp_t e;
        e.src = src;
        e.pay = pay;
        e.res = res;
        e.imm = imm;
        q.push_back(e);
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    // Waits for a grant, optionally schedules an ack in WAIT_ACK, then drops requests.
    task automatic grant_ack(input bit drop_a, input bit drop_b, input bit do_ack);
        bit ok;
        wait_gnt(ok);
        if (ok && do_ack) begin
            fork
                begin
                    repeat (10 * CPB + 1) @(negedge clk);
                    ack_in = 1'b1;
                    repeat (2) @(negedge clk);
                    ack_in = 1'b0;
                end
            join_none
        end
        @(posedge clk);
        #1;
        if (drop_a) req_a = 1'b0;
        if (drop_b) req_b = 1'b0;
    endtask

    // Monitor
    initial begin
        int   idle_cnt;
        int   res;
        int   wcnt;
        bit   aborted;
        bit   stray;
        logic expb;
        exp_t e;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                idle_cnt = 0;
                continue;
            end
            idle_cnt++;
            if (!(gnt_a || gnt_b)) begin
                chk("idle_busy", {31'd0, busy}, 0);
                chk("idle_pulse", {30'd0, done, err}, 0);
                continue;
            end
            if (q.size() == 0) begin
                chk("unexpected_gnt", {30'd0, gnt_a, gnt_b}, 0);
                continue;
            end
            e = q.pop_front();
            chk("gnt_src", {30'd0, gnt_a, gnt_b}, e.src ? 32'd1 : 32'd2);
            if (e.imm) chk("gnt_latency", idle_cnt, 1);
            idle_cnt = 0;
            aborted  = 1'b0;
            stray    = 1'b0;
            for (int k = 0; k < DW + 2 && !aborted; k++) begin
                if (k == 0)           expb = 1'b0;
                else if (k == DW + 1) expb = 1'b1;
                else                  expb = e.pay[k-1];
                for (int c = 0; c < CPB && !aborted; c++) begin
                    @(negedge clk);
                    if (!reset_n) begin
                        aborted = 1'b1;
                    end else begin
                        chk($sformatf("frame_bit%0d", k), {31'd0, data}, {31'd0, expb});
                        if (!busy || gnt_a || gnt_b || done || err) stray = 1'b1;
                    end
                end
            end
            if (aborted) begin
                chk("abort_kind", e.res, R_RST);
                chk("reset_line", {28'd0, data, busy, done, err}, 32'h8);
                continue;
            end
            chk("frame_pulses", {31'd0, stray}, 0);
            res  = R_NONE;
            wcnt = 0;
            while (res == R_NONE && wcnt < TO_CYC + 8) begin
                @(negedge clk);
                wcnt++;
                if (!reset_n)              res = R_RST;
                else if (done && err)      res = 4;
                else if (done)             res = R_DONE;
                else if (err)              res = R_ERR;
                else if (gnt_a || gnt_b)   res = 5;
                else if (!busy || !data)   res = 6;
            end
            chk("end_kind", res, e.res);
            if (e.res == R_ERR) chk("timeout_len", wcnt, TO_CYC);
            idle_cnt = 0;
        end
    end

    // Stimulus
    initial begin
        // Power-up with both requests held, then round-robin A,B,A,B.
        reset_n = 1'b0;
        req_a   = 1'b1;
        req_b   = 1'b1;
        data_a  = 8'h3C;
        data_b  = 8'hC3;
        push(1'b0, 8'h3C, R_DONE, 1'b1);
        push(1'b1, 8'hC3, R_DONE, 1'b1);
        push(1'b0, 8'h3C, R_DONE, 1'b1);
        push(1'b1, 8'hC3, R_DONE, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("rst_data", {31'd0, data}, 1);
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_gnt", {30'd0, gnt_a, gnt_b}, 0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) grant_ack(i == 3, i == 3, 1'b1);
        wait_idle();

        // Single A frame 0xA5; payload change after grant must not matter.
        @(posedge clk);
        #1;
        req_a  = 1'b1;
        data_a = 8'hA5;
        push(1'b0, 8'hA5, R_DONE, 1'b0);
        grant_ack(1'b1, 1'b0, 1'b1);
        data_a = 8'h00;
        wait_idle();

        // No ack: timeout; A requests during WAIT_ACK and is granted right after err.
        @(posedge clk);
        #1;
        req_b  = 1'b1;
        data_b = 8'h5A;
        push(1'b1, 8'h5A, R_ERR, 1'b0);
        grant_ack(1'b0, 1'b1, 1'b0);
        repeat (44) @(negedge clk);
        @(posedge clk);
        #1;
        req_a  = 1'b1;
        data_a = 8'h81;
        push(1'b0, 8'h81, R_DONE, 1'b1);

        // A frame with a stray ack during BITS and req_b raised during STOP.
        begin
            bit ok;
            wait_gnt(ok);
            @(posedge clk);
            #1 req_a = 1'b0;
            repeat (9) @(negedge clk);
            ack_in = 1'b1;
            repeat (3) @(negedge clk);
            ack_in = 1'b0;
            repeat (25) @(negedge clk);
            @(posedge clk);
            #1;
            req_b  = 1'b1;
            data_b = 8'h66;
            push(1'b1, 8'h66, R_DONE, 1'b1);
            repeat (2) @(negedge clk);
            ack_in = 1'b1;
            repeat (2) @(negedge clk);
            ack_in = 1'b0;
        end
        grant_ack(1'b0, 1'b1, 1'b1);
        wait_idle();

        // Reset during the 4th data bit, then a 0x01 frame.
        @(posedge clk);
        #1;
        req_a  = 1'b1;
        data_a = 8'hF0;
        push(1'b0, 8'hF0, R_RST, 1'b0);
        begin
            bit ok;
            wait_gnt(ok);
            @(posedge clk);
            #1 req_a = 1'b0;
            repeat (17) @(negedge clk);
            #1 reset_n = 1'b0;
            #1;
            chk("async_rst_line", {30'd0, data, busy}, 2);
            chk("async_rst_pulse", {30'd0, done, err}, 0);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_a  = 1'b1;
        data_a = 8'h01;
        push(1'b0, 8'h01, R_DONE, 1'b0);
        grant_ack(1'b1, 1'b0, 1'b1);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
